// File: rtl/keypad_digit_input.sv
// 4x4 matrix keypad scanner with 2-flop row synchroniser, sweep-level debounce and digit decode.
// Optional idle auto-blank of digitEn is enabled by defining KEYPAD_TIMEOUT_EN.
module keypad_digit_input #(
    parameter logic [15:0] SCAN_DIV       = 16'd50000,
    parameter logic [3:0]  DEBOUNCE_SCANS = 4'd4,
    parameter logic [15:0] TIMEOUT_SWEEPS = 16'd3000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] digit,
    output logic       digitEn,
    output logic       keyPulse
);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    logic [3:0]  rowsMeta_q, rowsSync_q;
    logic [15:0] divCnt_q, divCnt_d;
    logic [1:0]  colIdx_q, colIdx_d;
    logic [15:0] snap_q, snapNow;
    logic [1:0]  state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d, cntInc;
    logic [3:0]  digit_q, digit_d;
    logic        digitEn_q, digitEn_d;
    logic        keyPulse_q, keyPulse_d;
    logic        tick, sweepDone, accept;
    logic [4:0]  ones;
    logic [3:0]  keyIdx;
    logic        isNone, isSingle;
    logic [5:0]  keyInfo;

    // Returns {isDigit, isStar, value} for key index {row, col}.
    function automatic logic [5:0] decode_key(input logic [3:0] k);
        case (k)
            4'd0:    decode_key = {2'b10, 4'd1};
            4'd1:    decode_key = {2'b10, 4'd2};
            4'd2:    decode_key = {2'b10, 4'd3};
            4'd4:    decode_key = {2'b10, 4'd4};
            4'd5:    decode_key = {2'b10, 4'd5};
            4'd6:    decode_key = {2'b10, 4'd6};
            4'd8:    decode_key = {2'b10, 4'd7};
            4'd9:    decode_key = {2'b10, 4'd8};
            4'd10:   decode_key = {2'b10, 4'd9};
            4'd12:   decode_key = {2'b01, 4'd0};
            4'd13:   decode_key = {2'b10, 4'd0};
            default: decode_key = {2'b00, 4'd0};
        endcase
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        sat_inc4 = (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign tick      = (divCnt_q == SCAN_DIV - 16'd1);
    assign sweepDone = tick && (colIdx_q == 2'd3);
    assign cols      = ~(4'b0001 << colIdx_q);

    always_comb begin
        divCnt_d = tick ? 16'd0 : divCnt_q + 16'd1;
        colIdx_d = tick ? colIdx_q + 2'd1 : colIdx_q;
    end

    // Current column's sample merged in so a sweep is judged in the cycle it completes.
    always_comb begin
        snapNow = snap_q;
        snapNow[{2'd0, colIdx_q}] = ~rowsSync_q[0];
        snapNow[{2'd1, colIdx_q}] = ~rowsSync_q[1];
        snapNow[{2'd2, colIdx_q}] = ~rowsSync_q[2];
        snapNow[{2'd3, colIdx_q}] = ~rowsSync_q[3];
    end

    always_comb begin
        ones   = 5'd0;
        keyIdx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snapNow[i]) begin
                ones   = ones + 5'd1;
                keyIdx = 4'(i);
            end
        end
    end

    assign isNone   = (ones == 5'd0);
    assign isSingle = (ones == 5'd1);
    assign keyInfo  = decode_key(keyIdx);
    assign cntInc   = sat_inc4(cnt_q);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (sweepDone) begin
            case (state_q)
                ST_IDLE: begin
                    if (isSingle) begin
                        cand_d = keyIdx;
                        if (DEBOUNCE_SCANS <= 4'd1) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                            cnt_d   = 4'd0;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (isSingle && keyIdx == cand_q) begin
                        if (cntInc >= DEBOUNCE_SCANS) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cntInc;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                ST_HELD: begin
                    // Any activity re-arms the release count; only a clean run of empty sweeps releases.
                    if (isNone) begin
                        if (cntInc >= DEBOUNCE_SCANS) begin
                            state_d = ST_IDLE;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cntInc;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

`ifdef KEYPAD_TIMEOUT_EN
    logic [15:0] idleCnt_q, idleCnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_SWEEPS;
`endif

    always_comb begin
        digit_d    = digit_q;
        digitEn_d  = digitEn_q;
        keyPulse_d = 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
        idleCnt_d  = idleCnt_q;
`endif
        if (accept) begin
            if (keyInfo[5]) begin
                digit_d    = keyInfo[3:0];
                digitEn_d  = 1'b1;
                keyPulse_d = 1'b1;
            end else if (keyInfo[4]) begin
                digit_d    = 4'd0;
                digitEn_d  = 1'b0;
                keyPulse_d = 1'b1;
            end
`ifdef KEYPAD_TIMEOUT_EN
            idleCnt_d = 16'd0;
        end else if (sweepDone) begin
            idleCnt_d = (idleCnt_q == 16'hFFFF) ? idleCnt_q : idleCnt_q + 16'd1;
            if (idleCnt_d >= TIMEOUT_SWEEPS && digitEn_q) begin
                digitEn_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rowsMeta_q <= 4'hF;
            rowsSync_q <= 4'hF;
            divCnt_q   <= 16'd0;
            colIdx_q   <= 2'd0;
            snap_q     <= 16'd0;
            state_q    <= ST_IDLE;
            cand_q     <= 4'd0;
            cnt_q      <= 4'd0;
            digit_q    <= 4'd0;
            digitEn_q  <= 1'b0;
            keyPulse_q <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
            idleCnt_q  <= 16'd0;
`endif
        end else begin
            rowsMeta_q <= rows;
            rowsSync_q <= rowsMeta_q;
            divCnt_q   <= divCnt_d;
            colIdx_q   <= colIdx_d;
            if (tick) begin
                snap_q <= snapNow;
            end
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            digitEn_q  <= digitEn_d;
            keyPulse_q <= keyPulse_d;
`ifdef KEYPAD_TIMEOUT_EN
            idleCnt_q  <= idleCnt_d;
`endif
        end
    end

    assign digit    = digit_q;
    assign digitEn  = digitEn_q;
    assign keyPulse = keyPulse_q;
endmodule

// File: tb/tb_keypad_digit_input.sv
// Bench for keypad_digit_input: keypad matrix model, per-sweep behavioural reference, directed and random presses.
// Honours KEYPAD_TIMEOUT_EN the same way as the design.
module tb_keypad_digit_input;
    localparam int SD    = 4;
    localparam int DEB   = 3;
    localparam int TO    = 5;
    localparam int SWEEP = 4 * SD;
`ifdef KEYPAD_TIMEOUT_EN
    localparam int TO_ON = 1;
`else
    localparam int TO_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows, cols, digit;
    logic       digitEn, keyPulse;
    logic [15:0] pressed;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    // Reference model state
    int          n;
    logic [15:0] h1, h2, snap;
    bit          held;
    int          run, runKey, rel, idle;
    int          mdigit;
    bit          men, mpulse;
    logic [3:0]  expCols;
    // key value by index row*4+col: -1 ignored key, -2 clear key
    int keyval [16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, -2, 0, -1, -1};
    logic [3:0] colSeq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    keypad_digit_input #(
        .SCAN_DIV(16'd4),
        .DEBOUNCE_SCANS(4'd3),
        .TIMEOUT_SWEEPS(16'd5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rows(rows),
        .cols(cols),
        .digit(digit),
        .digitEn(digitEn),
        .keyPulse(keyPulse)
    );

    always #5 clk = ~clk;

    // Passive keypad: a pressed key shorts its row to the column currently driven low.
    function automatic logic [3:0] keypad_rows(input logic [15:0] pm, input logic [3:0] cdrv);
        logic [3:0] r;
        r = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (pm[rr*4+cc] && !cdrv[cc]) r[rr] = 1'b0;
        return r;
    endfunction

    assign rows = keypad_rows(pressed, cols);

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: capture inputs at the edge, advance the model, compare just after the edge.
    task automatic tick();
        logic        rs;
        logic [15:0] pm;
        int c, nb, cls, kv;
        bit acc;
        @(posedge clk);
        rs = reset;
        pm = pressed;
        #1;
        if (rs) begin
            n = 0; h1 = '0; h2 = '0; snap = '0;
            held = 0; run = 0; runKey = 0; rel = 0; idle = 0;
            mdigit = 0; men = 0; mpulse = 0;
            expCols = 4'b1110;
        end else begin
            mpulse = 0;
            if (n % SD == SD - 1) begin
                c = (n / SD) % 4;
                for (int r = 0; r < 4; r++) snap[r*4+c] = h2[r*4+c];
            end
            if (n % SWEEP == SWEEP - 1) begin
                nb  = $countones(snap);
                cls = (nb == 0) ? -1 : -2;
                if (nb == 1) for (int i = 0; i < 16; i++) if (snap[i]) cls = i;
                acc = 0;
                if (!held) begin
                    if (cls >= 0 && run > 0 && cls == runKey) run++;
                    else if (cls >= 0 && run == 0) begin run = 1; runKey = cls; end
                    else run = 0;
                    if (run >= DEB) begin acc = 1; held = 1; rel = 0; run = 0; end
                end else if (cls == -1) begin
                    rel++;
                    if (rel >= DEB) held = 0;
                end else begin
                    rel = 0;
                end
                if (acc) begin
                    idle = 0;
                    kv = keyval[runKey];
                    if (kv >= 0) begin mdigit = kv; men = 1; mpulse = 1; end
                    else if (kv == -2) begin mdigit = 0; men = 0; mpulse = 1; end
                end else if (TO_ON != 0) begin
                    if (idle < 65535) idle++;
                    if (idle >= TO && men) men = 0;
                end
            end
            h2 = h1;
            h1 = pm;
            n++;
            expCols = ~(4'b0001 << ((n / SD) % 4));
        end
        chk("cols", int'(cols), int'(expCols));
        chk("digit", int'(digit), mdigit);
        chk("digitEn", int'(digitEn), int'(men));
        chk("keyPulse", int'(keyPulse), int'(mpulse));
        if (keyPulse === 1'b1) pulses++;
        @(negedge clk);
    endtask

    task automatic hold(input logic [15:0] m, input int sweeps);
        pressed = m;
        repeat (sweeps * SWEEP) tick();
    endtask

    initial begin
        int base, sel, dur, a, b;
        logic [15:0] m;
        reset = 1'b1;
        pressed = '0;
        repeat (2) tick();
        chk("rst_cols", int'(cols), 4'b1110);
        chk("rst_digit", int'(digit), 0);
        chk("rst_digitEn", int'(digitEn), 0);
        chk("rst_keyPulse", int'(keyPulse), 0);
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            repeat (SD) tick();
            chk("scan_cols", int'(cols), int'(colSeq[j]));
        end

        // Bounce on key 5: short burst, gap, full burst
        base = pulses;
        hold(16'h0020, 2); hold(16'h0000, 1); hold(16'h0020, 3); hold(16'h0000, 4);
        chk("bounce_pulses", pulses - base, 1);
        chk("bounce_digit", int'(digit), 5);

        // Key 7 held for five sweeps
        base = pulses;
        hold(16'h0100, 5); hold(16'h0000, 4);
        chk("seven_pulses", pulses - base, 1);
        chk("seven_digit", int'(digit), 7);
        chk("seven_en", int'(digitEn), (TO_ON != 0) ? 0 : 1);

        // Clear key
        base = pulses;
        hold(16'h1000, 3); hold(16'h0000, 4);
        chk("star_pulses", pulses - base, 1);
        chk("star_digit", int'(digit), 0);
        chk("star_en", int'(digitEn), 0);

        // Ignored key
        base = pulses;
        hold(16'h4000, 3); hold(16'h0000, 4);
        chk("hash_pulses", pulses - base, 0);
        chk("hash_digit", int'(digit), 0);

        // Ghost: 2 and 3 together
        base = pulses;
        hold(16'h0006, 4); hold(16'h0000, 4);
        chk("multi_pulses", pulses - base, 0);

        // Key 4 with a short release glitch while held
        base = pulses;
        hold(16'h0010, 4); hold(16'h0000, 2); hold(16'h0010, 3); hold(16'h0000, 4);
        chk("glitch_pulses", pulses - base, 1);
        chk("glitch_digit", int'(digit), 4);

        // Key 6 held through a reset is accepted a second time
        base = pulses;
        hold(16'h0040, 4);
        reset = 1'b1; repeat (2) tick(); reset = 1'b0;
        hold(16'h0040, 4); hold(16'h0000, 4);
        chk("rstheld_pulses", pulses - base, 2);
        chk("rstheld_digit", int'(digit), 6);

        // Key 9 then a long idle
        hold(16'h0400, 4); hold(16'h0000, 4 * TO + 2);
        chk("idle_digit", int'(digit), 9);
        chk("idle_en", int'(digitEn), (TO_ON != 0) ? 0 : 1);

        // Random presses, combos and resets
        for (int it = 0; it < 250; it++) begin
            sel = $urandom_range(0, 9);
            if (sel == 9) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                reset = 1'b0;
            end else begin
                if (sel <= 2) begin
                    m = 16'h0000;
                    dur = $urandom_range(1, 60);
                end else if (sel <= 7) begin
                    m = 16'h0001 << $urandom_range(0, 15);
                    dur = $urandom_range(16, 100);
                end else begin
                    a = $urandom_range(0, 15);
                    b = $urandom_range(0, 15);
                    m = (16'h0001 << a) | (16'h0001 << b);
                    dur = $urandom_range(1, 60);
                end
                pressed = m;
                repeat (dur) tick();
            end
        end
        pressed = '0;
        repeat (5 * SWEEP) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
